// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults, address/data typedefs, zero-register address and range helper for the register bank
package reg_bank_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;
  localparam reg_addr_t ZERO_ADDR = '0;
  function automatic logic in_range(input int a, input int n);
    return a < n;
  endfunction
endpackage

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one async read port (addr in; data/busy out) with W1>W0 bypass, zero/range and busy masking
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [NREGS-1:0] busy_vec,
  input  logic            w0_en,
  input  logic [AW-1:0]   w0_addr,
  input  logic [XLEN-1:0] w0_data,
  input  logic            w1_en,
  input  logic [AW-1:0]   w1_addr,
  input  logic [XLEN-1:0] w1_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);
  logic ok, h0, h1;
  always_comb begin
    ok = in_range(int'(addr), NREGS) && !(ZERO_REG != 0 && addr == AW'(ZERO_ADDR));
    h1 = BYPASS != 0 && w1_en && w1_addr == addr;
    h0 = BYPASS != 0 && w0_en && w0_addr == addr;
    data = !ok ? '0 : h1 ? w1_data : h0 ? w0_data : regs[addr];
    busy = ok && !h0 && !h1 && busy_vec[addr];
  end
endmodule

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: 2R/2W register bank (RA/RB async reads + busy, W0/W1 sync writes, ISSUE sets busy, COLLISION flags same-address W0/W1)
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   RA_ADDR,
  output logic [XLEN-1:0] RA_DATA,
  output logic            RA_BUSY,
  input  logic [AW-1:0]   RB_ADDR,
  output logic [XLEN-1:0] RB_DATA,
  output logic            RB_BUSY,
  input  logic            W0_EN,
  input  logic [AW-1:0]   W0_ADDR,
  input  logic [XLEN-1:0] W0_DATA,
  input  logic            W1_EN,
  input  logic [AW-1:0]   W1_ADDR,
  input  logic [XLEN-1:0] W1_DATA,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_ADDR,
  output logic            COLLISION
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, set, clr;
  logic w0_ok, w1_ok, iss_ok;
  function automatic logic writable(input logic [AW-1:0] a);
    return in_range(int'(a), NREGS) && !(ZERO_REG != 0 && a == AW'(ZERO_ADDR));
  endfunction
  always_comb begin
    w0_ok = W0_EN && writable(W0_ADDR);
    w1_ok = W1_EN && writable(W1_ADDR);
    iss_ok = ISSUE_EN && writable(ISSUE_ADDR);
    for (int i = 0; i < NREGS; i++) begin
      set[i] = iss_ok && ISSUE_ADDR == AW'(i);
      clr[i] = (w0_ok && W0_ADDR == AW'(i)) || (w1_ok && W1_ADDR == AW'(i));
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
      COLLISION <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (w1_ok && W1_ADDR == AW'(i)) regs[i] <= W1_DATA;
        else if (w0_ok && W0_ADDR == AW'(i)) regs[i] <= W0_DATA;
      busy <= set | (busy & ~clr);
      COLLISION <= W0_EN && W1_EN && W0_ADDR == W1_ADDR && in_range(int'(W0_ADDR), NREGS);
    end
  reg_bank_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_ra (
    .addr(RA_ADDR), .regs(regs), .busy_vec(busy),
    .w0_en(W0_EN), .w0_addr(W0_ADDR), .w0_data(W0_DATA),
    .w1_en(W1_EN), .w1_addr(W1_ADDR), .w1_data(W1_DATA),
    .data(RA_DATA), .busy(RA_BUSY)
  );
  reg_bank_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rb (
    .addr(RB_ADDR), .regs(regs), .busy_vec(busy),
    .w0_en(W0_EN), .w0_addr(W0_ADDR), .w0_data(W0_DATA),
    .w1_en(W1_EN), .w1_addr(W1_ADDR), .w1_data(W1_DATA),
    .data(RB_DATA), .busy(RB_BUSY)
  );
endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: table-driven check of reg_bank_mp in bypass, no-bypass and 24-register builds
module tb_reg_bank_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ra, rb, w0a, w1a, ia;
  logic [31:0] w0d, w1d;
  logic w0e, w1e, ie;
  logic [31:0] ra_d, rb_d, nb_ra_d, nb_rb_d, s_ra_d, s_rb_d;
  logic ra_b, rb_b, col, nb_ra_b, nb_rb_b, nb_col, s_ra_b, s_rb_b, s_col;
  int cmp = 0;
  int err = 0;
  always #5 clk = ~clk;
  reg_bank_mp dut (
    .clk(clk), .rst_n(rst_n),
    .RA_ADDR(ra), .RA_DATA(ra_d), .RA_BUSY(ra_b),
    .RB_ADDR(rb), .RB_DATA(rb_d), .RB_BUSY(rb_b),
    .W0_EN(w0e), .W0_ADDR(w0a), .W0_DATA(w0d),
    .W1_EN(w1e), .W1_ADDR(w1a), .W1_DATA(w1d),
    .ISSUE_EN(ie), .ISSUE_ADDR(ia), .COLLISION(col)
  );
  reg_bank_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .RA_ADDR(ra), .RA_DATA(nb_ra_d), .RA_BUSY(nb_ra_b),
    .RB_ADDR(rb), .RB_DATA(nb_rb_d), .RB_BUSY(nb_rb_b),
    .W0_EN(w0e), .W0_ADDR(w0a), .W0_DATA(w0d),
    .W1_EN(w1e), .W1_ADDR(w1a), .W1_DATA(w1d),
    .ISSUE_EN(ie), .ISSUE_ADDR(ia), .COLLISION(nb_col)
  );
  reg_bank_mp #(.NREGS(24)) dut_24 (
    .clk(clk), .rst_n(rst_n),
    .RA_ADDR(ra), .RA_DATA(s_ra_d), .RA_BUSY(s_ra_b),
    .RB_ADDR(rb), .RB_DATA(s_rb_d), .RB_BUSY(s_rb_b),
    .W0_EN(w0e), .W0_ADDR(w0a), .W0_DATA(w0d),
    .W1_EN(w1e), .W1_ADDR(w1a), .W1_DATA(w1d),
    .ISSUE_EN(ie), .ISSUE_ADDR(ia), .COLLISION(s_col)
  );
  typedef struct {
    int rst, w0e, w0a, w0d, w1e, w1a, w1d, ie, ia, ra, rb;
    int era, erb, erab, erbb, ecol, nra, nrab;
  } vec_t;
  vec_t tbl [21];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle();
    rst_n = 1'b1;
    w0e = 1'b0; w0a = '0; w0d = '0;
    w1e = 1'b0; w1a = '0; w1d = '0;
    ie = 1'b0; ia = '0;
  endtask
  task automatic drive(input vec_t t);
    rst_n = t.rst[0];
    w0e = t.w0e[0]; w0a = 5'(t.w0a); w0d = 32'(t.w0d);
    w1e = t.w1e[0]; w1a = 5'(t.w1a); w1d = 32'(t.w1d);
    ie = t.ie[0]; ia = 5'(t.ia);
    ra = 5'(t.ra); rb = 5'(t.rb);
  endtask
  initial begin
    tbl[0]  = '{1,1,5,'h55,0,0,0,0,0,5,6,'h55,60,0,0,0,50,0};
    tbl[1]  = '{1,0,0,0,0,0,0,0,0,5,7,'h55,70,0,0,0,'h55,0};
    tbl[2]  = '{1,1,7,'h1111,1,7,'h2222,0,0,7,0,'h2222,0,0,0,0,70,0};
    tbl[3]  = '{1,0,0,0,0,0,0,0,0,7,7,'h2222,'h2222,0,0,1,'h2222,0};
    tbl[4]  = '{1,0,0,0,0,0,0,0,0,7,1,'h2222,10,0,0,0,'h2222,0};
    tbl[5]  = '{1,0,0,0,0,0,0,1,9,9,8,90,80,0,0,0,90,0};
    tbl[6]  = '{1,0,0,0,0,0,0,0,0,9,9,90,90,1,1,0,90,1};
    tbl[7]  = '{1,0,0,0,1,9,'hAB,0,0,9,10,'hAB,100,0,0,0,90,1};
    tbl[8]  = '{1,0,0,0,0,0,0,0,0,9,10,'hAB,100,0,0,0,'hAB,0};
    tbl[9]  = '{1,1,9,'hCD,0,0,0,1,9,9,8,'hCD,80,0,0,0,'hAB,0};
    tbl[10] = '{1,0,0,0,0,0,0,0,0,9,9,'hCD,'hCD,1,1,0,'hCD,1};
    tbl[11] = '{1,1,0,'h77,0,0,0,1,0,0,0,0,0,0,0,0,0,0};
    tbl[12] = '{1,0,0,0,0,0,0,0,0,0,1,0,10,0,0,0,0,0};
    tbl[13] = '{1,1,0,1,1,0,2,0,0,0,7,0,'h2222,0,0,0,0,0};
    tbl[14] = '{1,0,0,0,0,0,0,0,0,9,7,'hCD,'h2222,1,0,1,'hCD,1};
    tbl[15] = '{1,1,3,'h33,1,9,'h99,0,0,9,3,'h99,'h33,0,0,0,'hCD,1};
    tbl[16] = '{1,0,0,0,0,0,0,0,0,9,3,'h99,'h33,0,0,0,'h99,0};
    tbl[17] = '{1,1,3,'hDEAD,0,0,0,0,0,4,5,40,'h55,0,0,0,40,0};
    tbl[18] = '{0,1,3,'hBEEF,1,3,'hBEEF,1,3,5,4,'h55,40,0,0,0,'h55,0};
    tbl[19] = '{1,0,0,0,0,0,0,0,0,3,9,0,0,0,0,0,0,0};
    tbl[20] = '{1,0,0,0,0,0,0,0,0,5,7,0,0,0,0,0,0,0};
    idle();
    rst_n = 1'b0; ra = 5'd0; rb = 5'd1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; ra = 5'd3; rb = 5'd1;
    #4;
    chk("rst_ra", ra_d, 0);
    chk("rst_rb", rb_d, 0);
    chk("rst_rab", 32'(ra_b), 0);
    chk("rst_rbb", 32'(rb_b), 0);
    chk("rst_col", 32'(col), 0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      w0e = 1'b1; w0a = 5'(k); w0d = 32'(10 * k);
    end
    @(negedge clk);
    idle();
    for (int k = 0; k < 32; k += 2) begin
      @(negedge clk);
      ra = 5'(k); rb = 5'(k + 1);
      #4;
      chk($sformatf("fill_ra%0d", k), ra_d, k == 0 ? 0 : 32'(10 * k));
      chk($sformatf("fill_rb%0d", k + 1), rb_d, 32'(10 * (k + 1)));
      chk($sformatf("fill_busy%0d", k), 32'({ra_b, rb_b}), 0);
      chk($sformatf("n24_ra%0d", k), s_ra_d, (k > 0 && k < 24) ? 32'(10 * k) : 0);
      chk($sformatf("n24_rb%0d", k + 1), s_rb_d, (k + 1 < 24) ? 32'(10 * (k + 1)) : 0);
    end
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #4;
      chk($sformatf("v%0d_ra", i), ra_d, 32'(tbl[i].era));
      chk($sformatf("v%0d_rb", i), rb_d, 32'(tbl[i].erb));
      chk($sformatf("v%0d_rab", i), 32'(ra_b), 32'(tbl[i].erab));
      chk($sformatf("v%0d_rbb", i), 32'(rb_b), 32'(tbl[i].erbb));
      chk($sformatf("v%0d_col", i), 32'(col), 32'(tbl[i].ecol));
      chk($sformatf("v%0d_nb_ra", i), nb_ra_d, 32'(tbl[i].nra));
      chk($sformatf("v%0d_nb_rab", i), 32'(nb_ra_b), 32'(tbl[i].nrab));
      chk($sformatf("v%0d_n24_ra", i), s_ra_d, 32'(tbl[i].era));
      chk($sformatf("v%0d_n24_col", i), 32'(s_col), 32'(tbl[i].ecol));
    end
    @(negedge clk);
    idle();
    w0e = 1'b1; w0a = 5'd30; w0d = 32'hFFFF;
    w1e = 1'b1; w1a = 5'd30; w1d = 32'hEEEE;
    ie = 1'b1; ia = 5'd30;
    ra = 5'd30; rb = 5'd23;
    #4;
    chk("oor_n24_ra", s_ra_d, 0);
    chk("oor_n24_rab", 32'(s_ra_b), 0);
    chk("oor_main_byp", ra_d, 32'hEEEE);
    @(negedge clk);
    idle();
    ra = 5'd30; rb = 5'd6;
    #4;
    chk("oor_n24_ra2", s_ra_d, 0);
    chk("oor_n24_rab2", 32'(s_ra_b), 0);
    chk("oor_n24_col", 32'(s_col), 0);
    chk("oor_n24_r6", s_rb_d, 0);
    chk("oor_main_ra", ra_d, 32'hEEEE);
    chk("oor_main_busy", 32'(ra_b), 1);
    chk("oor_main_col", 32'(col), 1);
    @(negedge clk);
    w0e = 1'b1; w0a = 5'd0; w0d = 32'h5;
    ie = 1'b1; ia = 5'd0;
    ra = 5'd0; rb = 5'd14;
    #4;
    chk("z24_byp", s_ra_d, 0);
    chk("n24_r14", s_rb_d, 0);
    @(negedge clk);
    idle();
    ra = 5'd0; rb = 5'd0;
    #4;
    chk("z24_ra", s_ra_d, 0);
    chk("z24_rab", 32'(s_ra_b), 0);
    chk("z_main_rab", 32'(ra_b), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-port successor to the core's 2-read/1-write register bank. Provides two async read ports and two synchronous write ports: W0 for ALU writeback and W1 for load/late writeback. Adds optional write-to-read bypass, hardwired zero register and a per-register busy scoreboard for hazard detection. Sits between decode (reads, issue) and writeback in the RISC-V pipeline.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..64, need not be a power of two)
AW, $clog2(NREGS), address width (localparam, derived, not overridable)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
RA_ADDR  in  AW  read port A address
RA_DATA  out  XLEN  read port A data (combinational)
RA_BUSY  out  1  register at RA_ADDR has an outstanding producer
RB_ADDR  in  AW  read port B address
RB_DATA  out  XLEN  read port B data (combinational)
RB_BUSY  out  1  register at RB_ADDR has an outstanding producer
W0_EN  in  1  write port 0 enable
W0_ADDR  in  AW  write port 0 address
W0_DATA  in  XLEN  write port 0 data
W1_EN  in  1  write port 1 enable
W1_ADDR  in  AW  write port 1 address
W1_DATA  in  XLEN  write port 1 data
ISSUE_EN  in  1  mark destination register busy
ISSUE_ADDR  in  AW  destination register being issued
COLLISION  out  1  registered flag: previous cycle had W0/W1 to same address

Behaviour:
- Reset: rst_n low at a rising edge clears all registers to 0, all busy bits to 0, COLLISION to 0. Reset overrides every write and issue in that cycle. After the edge, RA_DATA/RB_DATA = 0 and RA_BUSY/RB_BUSY = 0.
- Write: at rising edge, Wn_EN=1 stores Wn_DATA at Wn_ADDR. Latency 1 cycle to storage.
- Write conflict: W0_EN and W1_EN both set, same address. W1 wins. COLLISION = 1 for exactly the following cycle, otherwise 0.
- Zero register (ZERO_REG=1): writes and issues to address 0 ignored. Reads of address 0 return 0, busy 0, even with bypass. Collision on address 0 is still flagged.
- Out-of-range addresses (>= NREGS): writes and issues ignored, reads return 0, busy 0, no collision flag.
- Read (combinational): BYPASS=1 priority is W1 match, then W0 match, then stored value. A match requires Wn_EN and Wn_ADDR == read address. BYPASS=0 always returns the stored value, so new data is visible the cycle after the write.
- Scoreboard: ISSUE_EN sets busy[ISSUE_ADDR] at the edge. Any write to an address clears its busy bit at the edge. Simultaneous issue and write to the same address leaves busy = 1, because the new producer wins.
- RA_BUSY = busy[RA_ADDR]. With BYPASS=1 it is forced to 0 when a same-cycle write matches RA_ADDR. RB_BUSY follows the same rule.
- No handshake: the caller guarantees ISSUE_EN is only asserted for valid decode.

Decomposition:
- Shared package reg_bank_pkg: XLEN_DEF=32, NREGS_DEF=32, ZERO_ADDR constant, reg_addr_t/reg_data_t typedefs sized from the defaults.
- One sub-module, reg_bank_rdport: address decode, bypass mux, zero/range masking and busy masking for one read port. Instantiated twice (A, B).
- Storage, scoreboard and collision flag live in the top module.

Test Plan:
- Reset, then write reg k = 10*k via W0 for k=0..31. Read pairs (k, k+1) on A/B -> reg0 = 0, regk = 10*k; both busy = 0.
- BYPASS=1: W0 write reg5 = 0x55 with RA_ADDR=5 in the same cycle -> RA_DATA = 0x55 before the edge. BYPASS=0 -> old value until the next cycle.
- W0 reg7 = 0x1111 and W1 reg7 = 0x2222 in the same cycle -> reg7 reads 0x2222; COLLISION = 1 for one cycle, then 0.
- ISSUE reg9 -> RA_BUSY = 1 next cycle. W1 reg9 = 0xAB -> busy clears after the edge. Issue and W0 to reg9 in the same cycle -> busy stays 1.
- Write reg3 = 0xDEAD, then assert rst_n = 0 during a cycle with W0 reg3 = 0xBEEF and ISSUE reg3 -> reg3 = 0, busy 0, COLLISION 0.
- NREGS=24: write address 30 = 0xFFFF -> read of address 30 = 0, no register changed; issue/write to address 0 -> reads 0, busy 0.
